// File: rtl/motor_cmd_receiver.sv
// motor_cmd_receiver
// Deserialises 16-bit SPI-mode-0 frames from the MCU into two motor
// sign/duty pairs. Values are committed atomically when load rises and are
// clamped to DUTY_MAX. A watchdog zeroes both duties when frames stop
// arriving. All asynchronous inputs are brought into clk through 2-flop
// synchronisers before use.
module motor_cmd_receiver #(
  parameter logic [6:0]  DUTY_MAX       = 7'd100,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_400_000,
  parameter int          FRAME_BITS     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       load,
  output logic       motor1_sign,
  output logic [6:0] motor1_upperlimit,
  output logic       motor2_sign,
  output logic [6:0] motor2_upperlimit,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       timed_out
);

  localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT   = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Duty field limiter: anything above the PWM counter limit saturates.
  function automatic logic [6:0] clamp_duty(input logic [6:0] duty);
    logic [6:0] res;
    if (duty > DUTY_MAX) begin
      res = DUTY_MAX;
    end else begin
      res = duty;
    end
    return res;
  endfunction

  // Synchroniser, history and arming flops
  logic       sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_hist_q, sck_hist_d;
  logic       sdi_s1_q, sdi_s1_d, sdi_s2_q, sdi_s2_d;
  logic       load_s1_q, load_s1_d, load_s2_q, load_s2_d, load_hist_q, load_hist_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;

  // Frame state
  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;

  // Committed outputs and watchdog
  logic        m1_sign_q, m1_sign_d, m2_sign_q, m2_sign_d;
  logic [6:0]  m1_duty_q, m1_duty_d, m2_duty_q, m2_duty_d;
  logic        frame_valid_q, frame_valid_d, frame_error_q, frame_error_d;
  logic [23:0] wd_cnt_q, wd_cnt_d;
  logic        timed_out_q, timed_out_d;

  // Edge terms and FSM control strobes
  logic sck_rise_s, load_rise_s, load_fall_s;
  logic start_frame_s, shift_en_s, in_commit_s;
  logic commit_ok_s, commit_err_s;

  assign sck_rise_s  = sck_s2_q & ~sck_hist_q;
  assign load_rise_s = load_s2_q & ~load_hist_q;
  assign load_fall_s = ~load_s2_q & load_hist_q;

  // Synchroniser chains; sdi only needs two stages since its edges are unused.
  always_comb begin
    sck_s1_d    = sck;
    sck_s2_d    = sck_s1_q;
    sck_hist_d  = sck_s2_q;
    sdi_s1_d    = sdi;
    sdi_s2_d    = sdi_s1_q;
    load_s1_d   = load;
    load_s2_d   = load_s1_q;
    load_hist_d = load_s2_q;
  end

  // Arming: only accept a frame start once load has been seen high with real
  // (post-reset) samples, so a transfer caught mid-flight by reset is ignored.
  always_comb begin
    if (settle_q == 2'd2) begin
      settle_d = settle_q;
      armed_d  = armed_q | load_s2_q;
    end else begin
      settle_d = settle_q + 2'd1;
      armed_d  = armed_q;
    end
  end

  // Synchroniser and arming registers; load idles high so reset shows no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_hist_q  <= 1'b0;
      sdi_s1_q    <= 1'b0;
      sdi_s2_q    <= 1'b0;
      load_s1_q   <= 1'b1;
      load_s2_q   <= 1'b1;
      load_hist_q <= 1'b1;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sck_s1_q    <= sck_s1_d;
      sck_s2_q    <= sck_s2_d;
      sck_hist_q  <= sck_hist_d;
      sdi_s1_q    <= sdi_s1_d;
      sdi_s2_q    <= sdi_s2_d;
      load_s1_q   <= load_s1_d;
      load_s2_q   <= load_s2_d;
      load_hist_q <= load_hist_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: COMMIT always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_fall_s && armed_q) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (load_rise_s) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: control strobes for the datapath.
  always_comb begin
    start_frame_s = 1'b0;
    shift_en_s    = 1'b0;
    in_commit_s   = 1'b0;
    case (state_q)
      ST_IDLE:   start_frame_s = load_fall_s & armed_q;
      ST_SHIFT:  shift_en_s    = sck_rise_s;
      ST_COMMIT: in_commit_s   = 1'b1;
      default: begin
        start_frame_s = 1'b0;
        shift_en_s    = 1'b0;
        in_commit_s   = 1'b0;
      end
    endcase
  end

  // Shift register and saturating bit counter; a bit arriving together with
  // load rise is still shifted before COMMIT inspects the count.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (start_frame_s) begin
      shift_d   = 16'h0000;
      bit_cnt_d = 5'd0;
    end else if (shift_en_s) begin
      shift_d = {shift_q[14:0], sdi_s2_q};
      if (bit_cnt_q >= CNT_SAT) begin
        bit_cnt_d = CNT_SAT;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Commit decision, watchdog and output values.
  always_comb begin
    commit_ok_s   = in_commit_s & (bit_cnt_q == FRAME_LEN);
    commit_err_s  = in_commit_s & (bit_cnt_q != FRAME_LEN);
    frame_valid_d = commit_ok_s;
    frame_error_d = commit_err_s;

    if (commit_ok_s) begin
      wd_cnt_d = 24'd0;
    end else if (wd_cnt_q >= TIMEOUT_CYCLES) begin
      wd_cnt_d = TIMEOUT_CYCLES;
    end else begin
      wd_cnt_d = wd_cnt_q + 24'd1;
    end
    timed_out_d = (wd_cnt_d == TIMEOUT_CYCLES);

    m1_sign_d = m1_sign_q;
    m2_sign_d = m2_sign_q;
    m1_duty_d = m1_duty_q;
    m2_duty_d = m2_duty_q;
    if (commit_ok_s) begin
      m1_sign_d = shift_q[15];
      m1_duty_d = clamp_duty(shift_q[14:8]);
      m2_sign_d = shift_q[7];
      m2_duty_d = clamp_duty(shift_q[6:0]);
    end else if (timed_out_d) begin
      m1_duty_d = 7'd0;
      m2_duty_d = 7'd0;
    end else begin
      m1_duty_d = m1_duty_q;
      m2_duty_d = m2_duty_q;
    end
  end

  // Frame datapath, committed outputs and watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q       <= 16'h0000;
      bit_cnt_q     <= 5'd0;
      m1_sign_q     <= 1'b0;
      m1_duty_q     <= 7'd0;
      m2_sign_q     <= 1'b0;
      m2_duty_q     <= 7'd0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      wd_cnt_q      <= 24'd0;
      timed_out_q   <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      m1_sign_q     <= m1_sign_d;
      m1_duty_q     <= m1_duty_d;
      m2_sign_q     <= m2_sign_d;
      m2_duty_q     <= m2_duty_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      wd_cnt_q      <= wd_cnt_d;
      timed_out_q   <= timed_out_d;
    end
  end

  assign motor1_sign       = m1_sign_q;
  assign motor1_upperlimit = m1_duty_q;
  assign motor2_sign       = m2_sign_q;
  assign motor2_upperlimit = m2_duty_q;
  assign frame_valid       = frame_valid_q;
  assign frame_error       = frame_error_q;
  assign timed_out         = timed_out_q;

endmodule

// File: tb/tb_motor_cmd_receiver.sv
// Bench for motor_cmd_receiver: directed frames, a frame-level model that
// predicts outputs every cycle, and literal spot checks.
module tb_motor_cmd_receiver;

  localparam int T = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       load = 1'b1;
  logic       motor1_sign, motor2_sign;
  logic [6:0] motor1_upperlimit, motor2_upperlimit;
  logic       frame_valid, frame_error, timed_out;

  motor_cmd_receiver #(
    .DUTY_MAX(7'd100),
    .TIMEOUT_CYCLES(24'(T)),
    .FRAME_BITS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sck(sck),
    .sdi(sdi),
    .load(load),
    .motor1_sign(motor1_sign),
    .motor1_upperlimit(motor1_upperlimit),
    .motor2_sign(motor2_sign),
    .motor2_upperlimit(motor2_upperlimit),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcount = 0;
  int ecount = 0;
  bit model_live = 1'b0;

  typedef struct {
    int  at_edge;
    bit  ok;
    int  val;
  } ev_t;
  ev_t evq[$];

  // model state
  int st_s1 = 0, st_d1 = 0, st_s2 = 0, st_d2 = 0;
  int wd = 0;
  int exp_v = 0, exp_e = 0;

  function automatic int clampi(input int d);
    return (d > 100) ? 100 : d;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Model: advances once per clock edge from frame events and the reset level.
  initial begin
    ev_t ev;
    bit commit_now;
    forever begin
      @(posedge clk);
      cyc++;
      exp_v = 0;
      exp_e = 0;
      if (reset) begin
        st_s1 = 0; st_d1 = 0; st_s2 = 0; st_d2 = 0;
        wd = 0;
        evq.delete();
      end else begin
        commit_now = 1'b0;
        if (evq.size() > 0 && evq[0].at_edge == cyc) begin
          ev = evq.pop_front();
          if (ev.ok) begin
            st_s1 = (ev.val >> 15) & 1;
            st_d1 = clampi((ev.val >> 8) & 127);
            st_s2 = (ev.val >> 7) & 1;
            st_d2 = clampi(ev.val & 127);
            exp_v = 1;
            commit_now = 1'b1;
          end else begin
            exp_e = 1;
          end
        end
        if (commit_now) wd = 0;
        else if (wd < T) wd++;
      end
      model_live = 1'b1;
    end
  end

  // Compare process: every cycle, on the falling edge.
  initial begin
    int to;
    forever begin
      @(negedge clk);
      if (model_live) begin
        to = (wd >= T) ? 1 : 0;
        chk("timed_out", int'(timed_out), to);
        chk("m1_sign", int'(motor1_sign), st_s1);
        chk("m2_sign", int'(motor2_sign), st_s2);
        chk("m1_duty", int'(motor1_upperlimit), to ? 0 : st_d1);
        chk("m2_duty", int'(motor2_upperlimit), to ? 0 : st_d2);
        chk("frame_valid", int'(frame_valid), exp_v);
        chk("frame_error", int'(frame_error), exp_e);
        if (frame_valid) vcount++;
        if (frame_error) ecount++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Sends n bits of val MSB first, sck period 10 clk, load low around it.
  task automatic send(input logic [16:0] val, input int n, input bit expect_commit);
    ev_t ev;
    load = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = val[i];
      sck = 1'b0;
      tick(5);
      sck = 1'b1;
      tick(5);
    end
    sck = 1'b0;
    tick(5);
    load = 1'b1;
    if (expect_commit) begin
      ev.at_edge = cyc + 4;
      ev.ok = (n == 16);
      ev.val = int'(val[15:0]);
      evq.push_back(ev);
    end
    tick(10);
  endtask

  task automatic lit(input string tag, input int s1, input int d1, input int s2,
                     input int d2, input int to);
    chk({tag, ".m1_sign"}, int'(motor1_sign), s1);
    chk({tag, ".m1_duty"}, int'(motor1_upperlimit), d1);
    chk({tag, ".m2_sign"}, int'(motor2_sign), s2);
    chk({tag, ".m2_duty"}, int'(motor2_upperlimit), d2);
    chk({tag, ".timed_out"}, int'(timed_out), to);
  endtask

  initial begin
    int v0, e0;
    logic [16:0] ones;
    ones = 17'h1FFFF;

    tick(5);
    reset = 1'b0;
    tick(10);
    lit("reset", 0, 0, 0, 0, 0);
    chk("reset.valid_cnt", vcount, 0);
    chk("reset.error_cnt", ecount, 0);

    // plain valid frame
    v0 = vcount; e0 = ecount;
    send(17'h08A32, 16, 1'b1);
    lit("f8A32", 1, 10, 0, 50, 0);
    chk("f8A32.valid_cnt", vcount - v0, 1);
    chk("f8A32.error_cnt", ecount - e0, 0);

    // clamp
    v0 = vcount;
    send(17'h07FFF, 16, 1'b1);
    lit("clamp", 0, 100, 1, 100, 0);
    chk("clamp.valid_cnt", vcount - v0, 1);

    // short and long frames
    send(17'h08A32, 16, 1'b1);
    v0 = vcount; e0 = ecount;
    send(17'h00FFF, 12, 1'b1);
    lit("short", 1, 10, 0, 50, 0);
    chk("short.error_cnt", ecount - e0, 1);
    send(ones, 17, 1'b1);
    lit("long", 1, 10, 0, 50, 0);
    chk("long.error_cnt", ecount - e0, 2);
    chk("badlen.valid_cnt", vcount - v0, 0);

    // watchdog
    send(17'h08A32, 16, 1'b1);
    tick(980);
    lit("wd_before", 1, 10, 0, 50, 0);
    tick(20);
    lit("wd_after", 1, 0, 0, 0, 1);
    send(17'h00505, 16, 1'b1);
    lit("wd_recover", 0, 5, 0, 5, 0);

    // sck noise with load high
    v0 = vcount; e0 = ecount;
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1;
      tick(5);
      sck = 1'b0;
      tick(5);
    end
    tick(10);
    lit("noise", 0, 5, 0, 5, 0);
    chk("noise.pulses", (vcount - v0) + (ecount - e0), 0);

    // reset in the middle of a frame
    load = 1'b0;
    tick(4);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
      end
      sdi = 1'b1;
      sck = 1'b0;
      tick(5);
      sck = 1'b1;
      tick(5);
    end
    sck = 1'b0;
    v0 = vcount; e0 = ecount;
    tick(5);
    load = 1'b1;
    tick(10);
    lit("rst_mid", 0, 0, 0, 0, 0);
    chk("rst_mid.pulses", (vcount - v0) + (ecount - e0), 0);
    v0 = vcount;
    send(17'h01020, 16, 1'b1);
    lit("f1020", 0, 16, 0, 32, 0);
    chk("f1020.valid_cnt", vcount - v0, 1);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
